// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, fetch FSM states
// and the instruction width used by the fetch stage and the control unit.
package instr_fetch_unit_pkg;

  localparam int INST_W = 32;

  localparam logic [1:0] PCSEL_HOLD   = 2'b00;
  localparam logic [1:0] PCSEL_INC    = 2'b01;
  localparam logic [1:0] PCSEL_BRANCH = 2'b10;
  localparam logic [1:0] PCSEL_REG    = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection. Every sum wraps modulo 2^AW. The
// misaligned flag is raised when the chosen target is not word aligned.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int AW    = 64,
  parameter int OFF_W = 26
) (
  input  logic [AW-1:0]    pc_i,
  input  logic [1:0]       pc_sel_i,
  input  logic [OFF_W-1:0] const_i,
  input  logic [AW-1:0]    br_addr_i,
  output logic [AW-1:0]    next_pc_o,
  output logic             misaligned_o
);

  localparam logic [AW-1:0] PC_STEP = AW'(4);

  logic signed [AW-1:0] off_ext;
  logic signed [AW-1:0] off_bytes;

  // Sign-extend the word offset, then scale it to a byte offset.
  assign off_ext   = {{(AW-OFF_W){const_i[OFF_W-1]}}, const_i};
  assign off_bytes = {off_ext[AW-3:0], 2'b00};

  // Pick the target address for the selected PC source.
  always_comb begin
    next_pc_o = pc_i;
    case (pc_sel_i)
      PCSEL_HOLD:   next_pc_o = pc_i;
      PCSEL_INC:    next_pc_o = pc_i + PC_STEP;
      PCSEL_BRANCH: next_pc_o = pc_i + off_bytes;
      PCSEL_REG:    next_pc_o = br_addr_i;
      default:      next_pc_o = pc_i;
    endcase
  end

  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and instruction register, sequences RAM reads with a
// FETCH/EXEC/FAULT FSM and a watchdog on unanswered fetches. All outputs are
// decoded from registered state.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              AW            = 64,
  parameter int              IW            = INST_W,
  parameter int              OFF_W         = 26,
  parameter logic [AW-1:0]   RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [1:0]       PC_SEL,
  input  logic [OFF_W-1:0] Const,
  input  logic [AW-1:0]    BR_Addr,
  input  logic             Exec_Done,
  input  logic             Mem_Ack,
  input  logic [IW-1:0]    Mem_RData,
  output logic             Mem_Req,
  output logic [AW-1:0]    Mem_Addr,
  output logic             EN_ADDR_PC,
  output logic [IW-1:0]    Inst,
  output logic             Inst_Valid,
  output logic [AW-1:0]    PC,
  output logic             Fetch_Fault
);

  localparam int               CNT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [IW-1:0]    inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [AW-1:0]    next_pc;
  logic             next_misaligned;

  pc_next_calc #(
    .AW    (AW),
    .OFF_W (OFF_W)
  ) u_pc_next_calc (
    .pc_i         (pc_q),
    .pc_sel_i     (PC_SEL),
    .const_i      (Const),
    .br_addr_i    (BR_Addr),
    .next_pc_o    (next_pc),
    .misaligned_o (next_misaligned)
  );

  // Next-state logic: fetch handshake with watchdog, PC update on retire.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: begin
        // An ack in the last watchdog cycle still completes the fetch.
        if (Mem_Ack) begin
          inst_d  = Mem_RData;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        // A misaligned target faults without disturbing PC.
        if (Exec_Done) begin
          if (next_misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State, PC, IR and watchdog registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Mem_Req     = (state_q == ST_FETCH);
  assign EN_ADDR_PC  = Mem_Req;
  assign Mem_Addr    = pc_q;
  assign PC          = pc_q;
  assign Inst        = inst_q;
  assign Inst_Valid  = (state_q == ST_EXEC);
  assign Fetch_Fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// against an arithmetic model of the program counter.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  PC_SEL = 2'b00;
  logic [25:0] Const = '0;
  logic [63:0] BR_Addr = '0;
  logic        Exec_Done = 1'b0;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData = '0;
  logic        Mem_Req, EN_ADDR_PC, Inst_Valid, Fetch_Fault;
  logic [63:0] Mem_Addr, PC;
  logic [31:0] Inst;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .Reset       (Reset),
    .PC_SEL      (PC_SEL),
    .Const       (Const),
    .BR_Addr     (BR_Addr),
    .Exec_Done   (Exec_Done),
    .Mem_Ack     (Mem_Ack),
    .Mem_RData   (Mem_RData),
    .Mem_Req     (Mem_Req),
    .Mem_Addr    (Mem_Addr),
    .EN_ADDR_PC  (EN_ADDR_PC),
    .Inst        (Inst),
    .Inst_Valid  (Inst_Valid),
    .PC          (PC),
    .Fetch_Fault (Fetch_Fault)
  );

  always #5 clk = ~clk;

  // Reference next-PC: plain integer arithmetic on the select rules.
  function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [1:0] sel,
                                             input logic [25:0] c, input logic [63:0] br);
    longint off;
    off = longint'(c);
    if (off >= 33554432) off = off - 67108864;
    case (sel)
      2'd0: return pc;
      2'd1: return pc + 64'd4;
      2'd2: return pc + 64'(off * 4);
      default: return br;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Mem_Ack = 1'b0; Exec_Done = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  // Answer the pending fetch after 'dly' idle cycles.
  task automatic fetch(input int dly, input logic [31:0] data);
    Mem_Ack = 1'b0;
    repeat (dly) tick();
    Mem_Ack = 1'b1; Mem_RData = data;
    tick();
    Mem_Ack = 1'b0; Mem_RData = '0;
  endtask

  task automatic retire(input logic [1:0] sel, input logic [25:0] c, input logic [63:0] br);
    PC_SEL = sel; Const = c; BR_Addr = br; Exec_Done = 1'b1;
    tick();
    Exec_Done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Mem_Ack = 1'b1; Exec_Done = 1'b1; Mem_RData = 32'hFFFF_FFFF;
    tick(); tick();
    Reset = 1'b0; Mem_Ack = 1'b0; Exec_Done = 1'b0; Mem_RData = '0;
    checks++; if (Mem_Req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", Mem_Req); end
    checks++; if (EN_ADDR_PC !== 1'b1) begin errors++; $display("FAIL reset_en got %b exp 1", EN_ADDR_PC); end
    checks++; if (Mem_Addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", Mem_Addr); end
    checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", Inst); end
    checks++; if (Inst_Valid !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", Inst_Valid); end
    checks++; if (Fetch_Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", Fetch_Fault); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    fetch(1, 32'h9100_0421);
    checks++; if (Inst !== 32'h9100_0421) begin errors++; $display("FAIL first_inst got %h exp 91000421", Inst); end
    checks++; if (Inst_Valid !== 1'b1) begin errors++; $display("FAIL first_vld got %b exp 1", Inst_Valid); end
    checks++; if (Mem_Req !== 1'b0) begin errors++; $display("FAIL first_req got %b exp 0", Mem_Req); end
    checks++; if (PC !== 64'h0) begin errors++; $display("FAIL first_pc got %h exp 0", PC); end
    // Ack in EXEC must not overwrite the instruction register.
    Mem_Ack = 1'b1; Mem_RData = 32'h1234_5678;
    tick(); tick();
    Mem_Ack = 1'b0;
    checks++; if (Inst !== 32'h9100_0421) begin errors++; $display("FAIL exec_ack_ignored got %h exp 91000421", Inst); end
    checks++; if (Inst_Valid !== 1'b1) begin errors++; $display("FAIL exec_wait_vld got %b exp 1", Inst_Valid); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_addr;
    do_reset();
    exp_addr = 64'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (Mem_Addr !== exp_addr || Mem_Req !== 1'b1) begin
        errors++; $display("FAIL seq_addr%0d got %h req %b exp %h", i, Mem_Addr, Mem_Req, exp_addr);
      end
      if (i < 4) begin
        fetch(0, 32'h1000_0000 + i);
        retire(2'b01, '0, '0);
        exp_addr = exp_addr + 64'd4;
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    fetch(0, 32'h0);
    retire(2'b11, '0, 64'h100);
    fetch(0, 32'h0);
    retire(2'b10, 26'h3FF_FFFE, '0);
    checks++; if (Mem_Addr !== 64'hF8) begin errors++; $display("FAIL branch_neg got %h exp f8", Mem_Addr); end
    fetch(0, 32'h0);
    retire(2'b11, '0, 64'h100);
    fetch(0, 32'h0);
    retire(2'b10, 26'h1, '0);
    checks++; if (Mem_Addr !== 64'h104) begin errors++; $display("FAIL branch_pos got %h exp 104", Mem_Addr); end
    fetch(0, 32'h0);
    retire(2'b00, '0, '0);
    checks++; if (Mem_Addr !== 64'h104 || Mem_Req !== 1'b1) begin
      errors++; $display("FAIL hold_refetch got %h req %b exp 104", Mem_Addr, Mem_Req);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    fetch(0, 32'h0);
    retire(2'b11, '0, 64'h40);
    fetch(0, 32'hABCD_0001);
    retire(2'b11, '0, 64'h2002);
    checks++; if (Fetch_Fault !== 1'b1) begin errors++; $display("FAIL misal_fault got %b exp 1", Fetch_Fault); end
    checks++; if (Mem_Req !== 1'b0) begin errors++; $display("FAIL misal_req got %b exp 0", Mem_Req); end
    checks++; if (PC !== 64'h40) begin errors++; $display("FAIL misal_pc got %h exp 40", PC); end
    checks++; if (Inst_Valid !== 1'b0) begin errors++; $display("FAIL misal_vld got %b exp 0", Inst_Valid); end
    // FAULT is sticky against acks and retire pulses.
    Mem_Ack = 1'b1; Exec_Done = 1'b1; PC_SEL = 2'b01;
    tick(); tick();
    Mem_Ack = 1'b0; Exec_Done = 1'b0;
    checks++; if (Fetch_Fault !== 1'b1 || PC !== 64'h40 || Mem_Req !== 1'b0) begin
      errors++; $display("FAIL fault_sticky got fault %b pc %h req %b exp 1 40 0", Fetch_Fault, PC, Mem_Req);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch(0, 32'h0);
    retire(2'b11, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    checks++; if (Mem_Addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffffffffffc", Mem_Addr); end
    fetch(0, 32'h0);
    retire(2'b01, '0, '0);
    checks++; if (Mem_Addr !== 64'h0 || Fetch_Fault !== 1'b0) begin
      errors++; $display("FAIL wrap_zero got %h fault %b exp 0 0", Mem_Addr, Fetch_Fault);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (14) tick();
    checks++; if (Fetch_Fault !== 1'b0 || Mem_Req !== 1'b1) begin
      errors++; $display("FAIL timeout_early got fault %b req %b exp 0 1", Fetch_Fault, Mem_Req);
    end
    tick();
    checks++; if (Fetch_Fault !== 1'b1 || Mem_Req !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got fault %b req %b exp 1 0", Fetch_Fault, Mem_Req);
    end
    do_reset();
    fetch(14, 32'h5555_AAAA);
    checks++; if (Fetch_Fault !== 1'b0 || Inst_Valid !== 1'b1 || Inst !== 32'h5555_AAAA) begin
      errors++; $display("FAIL timeout_last_ack got fault %b vld %b inst %h exp 0 1 5555aaaa", Fetch_Fault, Inst_Valid, Inst);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    fetch(0, 32'h0);
    retire(2'b11, '0, 64'h80);
    Exec_Done = 1'b1; PC_SEL = 2'b01;
    tick();
    Exec_Done = 1'b0;
    checks++; if (Mem_Addr !== 64'h80 || Mem_Req !== 1'b1) begin
      errors++; $display("FAIL fetch_done_ignored got %h req %b exp 80 1", Mem_Addr, Mem_Req);
    end
    Reset = 1'b1; Mem_Ack = 1'b1; Mem_RData = 32'hDEAD_BEEF;
    tick();
    Reset = 1'b0; Mem_Ack = 1'b0; Mem_RData = '0;
    tick();
    checks++; if (Mem_Addr !== 64'h0 || Mem_Req !== 1'b1 || Inst !== 32'h0 || Inst_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid got addr %h req %b inst %h vld %b exp 0 1 0 0", Mem_Addr, Mem_Req, Inst, Inst_Valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetch(0, 32'h0000_0011);
    retire(2'b01, '0, '0);
    checks++; if (Mem_Req !== 1'b1 || Mem_Addr !== 64'h4) begin
      errors++; $display("FAIL b2b_req got req %b addr %h exp 1 4", Mem_Req, Mem_Addr);
    end
    fetch(0, 32'h0000_0022);
    checks++; if (Inst !== 32'h0000_0022 || Inst_Valid !== 1'b1) begin
      errors++; $display("FAIL b2b_inst got %h vld %b exp 22 1", Inst, Inst_Valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] m_pc, nxt, br;
    logic [31:0] data;
    logic [25:0] c;
    logic [1:0]  sel;
    do_reset();
    m_pc = 64'h0;
    for (int i = 0; i < 60; i++) begin
      data = $urandom;
      fetch($urandom_range(0, 4), data);
      checks++; if (Inst !== data || Inst_Valid !== 1'b1 || PC !== m_pc) begin
        errors++; $display("FAIL rnd_fetch%0d got inst %h vld %b pc %h exp %h 1 %h", i, Inst, Inst_Valid, PC, data, m_pc);
      end
      Mem_Ack = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) tick();
      Mem_Ack = 1'b0;
      sel = 2'($urandom_range(0, 3));
      c   = 26'($urandom);
      br  = {$urandom, $urandom};
      if ($urandom_range(0, 5) != 0) br[1:0] = 2'b00;
      nxt = model_next(m_pc, sel, c, br);
      retire(sel, c, br);
      if (nxt[1:0] != 2'b00) begin
        checks++; if (Fetch_Fault !== 1'b1 || PC !== m_pc) begin
          errors++; $display("FAIL rnd_fault%0d got fault %b pc %h exp 1 %h", i, Fetch_Fault, PC, m_pc);
        end
        do_reset();
        m_pc = 64'h0;
      end else begin
        checks++; if (Mem_Req !== 1'b1 || Mem_Addr !== nxt || Fetch_Fault !== 1'b0) begin
          errors++; $display("FAIL rnd_next%0d got req %b addr %h fault %b exp 1 %h 0", i, Mem_Req, Mem_Addr, Fetch_Fault, nxt);
        end
        m_pc = nxt;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_misaligned();
    test_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
